// File: rtl/seg_scan_if.sv
// Display-side bus for seg_scan_ctrl: scan clock, enable, value and decimal points in; digit/segment drives out.
// The master drives the display request, the slave (scanner) drives the LED lines.
interface seg_scan_if;
  logic        scan_clk_i;
  logic        en_i;
  logic [31:0] data_i;
  logic [7:0]  dp_i;
  logic [7:0]  led_en_o;
  logic [7:0]  seg_o;

  modport master (
    output scan_clk_i,
    output en_i,
    output data_i,
    output dp_i,
    input  led_en_o,
    input  seg_o
  );

  modport slave (
    input  scan_clk_i,
    input  en_i,
    input  data_i,
    input  dp_i,
    output led_en_o,
    output seg_o
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Eight-digit time-multiplexed seven-segment scanner; scan_clk_i is sampled as data and each rising edge shows the next digit.
// Build macro SEG_BLANK_LZ_EN enables leading-zero blanking; without it every digit is decoded.
module seg_scan_ctrl (
  input  logic      clk_i,
  input  logic      rst_n_i,
  seg_scan_if.slave bus
);

  logic        s1_r;
  logic        s2_r;
  logic        s3_r;
  logic        tick_s;
  logic        wrap_s;
  logic [2:0]  idx_r;
  logic [2:0]  idx_next_s;
  logic [31:0] shadow_data_r;
  logic [7:0]  shadow_dp_r;
  logic [31:0] frame_data_s;
  logic [7:0]  frame_dp_s;
  logic [3:0]  nibble_s;
  logic        dp_bit_s;
  logic [6:0]  glyph_s;
  logic [7:0]  led_en_next_s;
  logic [7:0]  seg_next_s;
  logic [7:0]  led_en_r;
  logic [7:0]  seg_r;

  function automatic logic [6:0] decode7(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'h40;
      4'h1:    g = 7'h79;
      4'h2:    g = 7'h24;
      4'h3:    g = 7'h30;
      4'h4:    g = 7'h19;
      4'h5:    g = 7'h12;
      4'h6:    g = 7'h02;
      4'h7:    g = 7'h78;
      4'h8:    g = 7'h00;
      4'h9:    g = 7'h10;
      4'hA:    g = 7'h08;
      4'hB:    g = 7'h03;
      4'hC:    g = 7'h46;
      4'hD:    g = 7'h21;
      4'hE:    g = 7'h06;
      4'hF:    g = 7'h0E;
      default: g = 7'h7F;
    endcase
    return g;
  endfunction

`ifdef SEG_BLANK_LZ_EN
  // Index of the most significant non-zero nibble; an all-zero value reports digit 0.
  function automatic logic [2:0] top_digit(input logic [31:0] v);
    logic [2:0] t;
    t = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (v[4*i +: 4] != 4'h0) begin
        t = 3'(i);
      end else begin
        t = t;
      end
    end
    return t;
  endfunction
`endif

  assign tick_s     = s2_r & ~s3_r;
  assign wrap_s     = (idx_r == 3'd7);
  assign idx_next_s = idx_r + 3'd1;

  // Next digit's drive values; on the wrap the freshly presented value is used so the new frame starts consistent.
  always_comb begin
    frame_data_s  = shadow_data_r;
    frame_dp_s    = shadow_dp_r;
    led_en_next_s = 8'hFF;
    if (wrap_s) begin
      frame_data_s = bus.data_i;
      frame_dp_s   = bus.dp_i;
    end else begin
      frame_data_s = shadow_data_r;
      frame_dp_s   = shadow_dp_r;
    end
    nibble_s = frame_data_s[{idx_next_s, 2'b00} +: 4];
    dp_bit_s = frame_dp_s[idx_next_s];
`ifdef SEG_BLANK_LZ_EN
    if ((idx_next_s != 3'd0) && (idx_next_s > top_digit(frame_data_s))) begin
      glyph_s = 7'h7F;
    end else begin
      glyph_s = decode7(nibble_s);
    end
`else
    glyph_s = decode7(nibble_s);
`endif
    if (bus.en_i) begin
      led_en_next_s = ~(8'b1 << idx_next_s);
    end else begin
      led_en_next_s = 8'hFF;
    end
    seg_next_s = {~dp_bit_s, glyph_s};
  end

  // Synchronizer, digit index, frame snapshot and registered display outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      s1_r          <= 1'b0;
      s2_r          <= 1'b0;
      s3_r          <= 1'b0;
      idx_r         <= 3'd7;
      shadow_data_r <= 32'h0000_0000;
      shadow_dp_r   <= 8'h00;
      led_en_r      <= 8'hFF;
      seg_r         <= 8'hFF;
    end else begin
      s1_r <= bus.scan_clk_i;
      s2_r <= s1_r;
      s3_r <= s2_r;
      if (tick_s) begin
        idx_r    <= idx_next_s;
        led_en_r <= led_en_next_s;
        seg_r    <= seg_next_s;
        if (wrap_s) begin
          shadow_data_r <= bus.data_i;
          shadow_dp_r   <= bus.dp_i;
        end else begin
          shadow_data_r <= shadow_data_r;
          shadow_dp_r   <= shadow_dp_r;
        end
      end else begin
        idx_r    <= idx_r;
        led_en_r <= led_en_r;
        seg_r    <= seg_r;
      end
    end
  end

  assign bus.led_en_o = led_en_r;
  assign bus.seg_o    = seg_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: a frame-level display model checked every cycle, plus hand-computed literals.
// Build with SEG_BLANK_LZ_EN defined to also exercise leading-zero blanking.
module tb_seg_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  logic cmp_on = 1'b0;

  seg_scan_if bus();

  seg_scan_ctrl dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [7:0] led_lit [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [7:0] seq_lit [8] = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};

  // Model state: a scan-clock rise seen at edge k becomes a displayed digit at edge k+2.
  logic        m_prev, m_rise_a, m_rise_b;
  int          m_digit;
  logic [31:0] m_data;
  logic [7:0]  m_dp;
  logic [7:0]  m_led, m_seg;

  function automatic logic [7:0] model_seg(input logic [31:0] v, input logic [7:0] dp, input int d);
    logic [7:0] s;
    s    = seg_tab[v[4*d +: 4]];
    s[7] = ~dp[d];
`ifdef SEG_BLANK_LZ_EN
    begin
      int top;
      top = 0;
      for (int i = 0; i < 8; i++) if (v[4*i +: 4] != 4'h0) top = i;
      if (d > top) s[6:0] = 7'h7F;
    end
`endif
    return s;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_prev   <= 1'b0;
      m_rise_a <= 1'b0;
      m_rise_b <= 1'b0;
      m_digit  <= 0;
      m_data   <= 32'h0;
      m_dp     <= 8'h0;
      m_led    <= 8'hFF;
      m_seg    <= 8'hFF;
    end else begin
      m_rise_b <= m_rise_a;
      m_rise_a <= bus.scan_clk_i & ~m_prev;
      m_prev   <= bus.scan_clk_i;
      if (m_rise_b) begin
        if (m_digit == 0) begin
          m_data <= bus.data_i;
          m_dp   <= bus.dp_i;
        end
        m_led   <= bus.en_i ? ~(8'd1 << m_digit) : 8'hFF;
        m_seg   <= model_seg((m_digit == 0) ? bus.data_i : m_data,
                             (m_digit == 0) ? bus.dp_i : m_dp, m_digit);
        m_digit <= (m_digit + 1) % 8;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      total++;
      if (bus.led_en_o !== m_led) begin
        bad++;
        $display("FAIL model_led t=%0t: got %h want %h", $time, bus.led_en_o, m_led);
      end
      total++;
      if (bus.seg_o !== m_seg) begin
        bad++;
        $display("FAIL model_seg t=%0t: got %h want %h", $time, bus.seg_o, m_seg);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // mode 0: model only; 1: literal result; 2: literal result plus hold-until-k+2 check against old values.
  task automatic pulse(input int mode, input logic [7:0] old_led, input logic [7:0] old_seg,
                       input logic [7:0] led, input logic [7:0] seg);
    bus.scan_clk_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    if (mode == 2) begin
      chk("hold_led", bus.led_en_o, old_led);
      chk("hold_seg", bus.seg_o, old_seg);
    end
    @(posedge clk); #1;
    if (mode != 0) begin
      chk("lit_led", bus.led_en_o, led);
      chk("lit_seg", bus.seg_o, seg);
    end
    bus.scan_clk_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.scan_clk_i = 1'b0;
    bus.en_i       = 1'b1;
    bus.data_i     = 32'h0;
    bus.dp_i       = 8'h0;
    @(posedge clk); #1;
    cmp_on = 1'b1;
    chk("rst_led", bus.led_en_o, 8'hFF);
    chk("rst_seg", bus.seg_o, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      bus.scan_clk_i = ~bus.scan_clk_i;
      @(posedge clk); #1;
      chk("rst_tog_led", bus.led_en_o, 8'hFF);
      chk("rst_tog_seg", bus.seg_o, 8'hFF);
    end
    bus.scan_clk_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("idle_led", bus.led_en_o, 8'hFF);
    chk("idle_seg", bus.seg_o, 8'hFF);

    // Scan sequence with latency check
    bus.data_i = 32'h1234_5678;
    pulse(2, 8'hFF, 8'hFF, led_lit[0], seq_lit[0]);
    for (int i = 1; i < 8; i++) pulse(2, led_lit[i-1], seq_lit[i-1], led_lit[i], seq_lit[i]);

    // Snapshot: a mid-frame change waits for the next frame
    for (int i = 0; i < 4; i++) pulse(1, 8'h00, 8'h00, led_lit[i], seq_lit[i]);
    bus.data_i = 32'hFFFF_FFFF;
    for (int i = 4; i < 8; i++) pulse(1, 8'h00, 8'h00, led_lit[i], seq_lit[i]);
    for (int i = 0; i < 8; i++) pulse(1, 8'h00, 8'h00, led_lit[i], 8'h8E);

    // Disabled frame, then re-enable mid-frame at digit 3
    bus.en_i = 1'b0;
    for (int i = 0; i < 11; i++) pulse(1, 8'h00, 8'h00, 8'hFF, 8'h8E);
    bus.en_i = 1'b1;
    pulse(1, 8'h00, 8'h00, 8'hF7, 8'h8E);

    // Held-high scan clock yields one tick (digit 4)
    bus.scan_clk_i = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk("held_led", bus.led_en_o, 8'hEF);
    chk("held_seg", bus.seg_o, 8'h8E);
    bus.scan_clk_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    pulse(1, 8'h00, 8'h00, 8'hDF, 8'h8E);

    // Reset mid-frame at digit 5
    bus.data_i = 32'h1234_5670;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_led", bus.led_en_o, 8'hFF);
    chk("midrst_seg", bus.seg_o, 8'hFF);
    rst_n = 1'b1;
    @(posedge clk); #1;
    pulse(1, 8'h00, 8'h00, 8'hFE, 8'hC0);
    pulse(1, 8'h00, 8'h00, 8'hFD, 8'hF8);

    // Decimal points on digits 0 and 7
    bus.data_i = 32'hFEDC_BA90;
    bus.dp_i   = 8'h81;
    for (int i = 2; i < 8; i++) pulse(0, 8'h00, 8'h00, 8'h00, 8'h00);
    pulse(1, 8'h00, 8'h00, 8'hFE, 8'h40);
    for (int i = 1; i < 7; i++) pulse(0, 8'h00, 8'h00, 8'h00, 8'h00);
    pulse(1, 8'h00, 8'h00, 8'h7F, 8'h0E);

`ifdef SEG_BLANK_LZ_EN
    bus.data_i = 32'h0000_0A05;
    bus.dp_i   = 8'h04;
    pulse(1, 8'h00, 8'h00, 8'hFE, 8'h92);
    pulse(1, 8'h00, 8'h00, 8'hFD, 8'hC0);
    pulse(1, 8'h00, 8'h00, 8'hFB, 8'h08);
    for (int i = 3; i < 8; i++) pulse(1, 8'h00, 8'h00, led_lit[i], 8'hFF);
`endif

    repeat (3) @(posedge clk);
    #1;
    cmp_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
